avaliacao_apurador: RTL and testbench
=====================================

Name: avaliacao_apurador

Overview:
- Sequential stage directly downstream of the combinational evaluator `principal`.
- Samples the evaluator's 2-bit verdict {y1,y0} on a strobe over one evaluation round of N_AVAL samples.
- Keeps a per-code tally and, at round end, registers the majority verdict plus the four tallies for display or reporting logic.

Parameters:
- N_AVAL, 8, number of samples per round; legal range 1..15.
- W_CONT, 4, width of each tally and of the sample counter; must satisfy 2^W_CONT > N_AVAL.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- inicio  input  1  start-of-round request, level sampled each clock.
- amostra  input  1  sample strobe; {y1,y0} is valid when high.
- y1  input  1  verdict MSB from `principal`.
- y0  input  1  verdict LSB from `principal`.
- ocupado  output  1  high while a round is collecting or tallying.
- pronto  output  1  high while a finished result is held.
- resultado  output  2  majority verdict code of the last finished round.
- c00  output  W_CONT  tally of code 00.
- c01  output  W_CONT  tally of code 01.
- c10  output  W_CONT  tally of code 10.
- c11  output  W_CONT  tally of code 11.
- n_amostras  output  W_CONT  samples accepted in the current round.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting rst immediately forces state OCIOSO.
  - It clears ocupado, pronto, resultado, c00..c11 and n_amostras to 0.
  - Reset mid-round discards the round with no partial result.
  - Release is synchronous to clk.
- FSM states: OCIOSO, COLETANDO, APURANDO, CONCLUIDO (binary encoding, registered outputs).
- OCIOSO:
  - ocupado=0, pronto=0.
  - amostra is ignored.
  - inicio=1 → COLETANDO; on the same edge, all tallies and n_amostras clear to 0.
- COLETANDO:
  - ocupado=1.
  - Each clock with amostra=1 increments the tally selected by {y1,y0} by 1 and increments n_amostras by 1.
  - amostra=0 holds all counts.
  - When amostra=1 and n_amostras==N_AVAL-1, that sample is counted and the next state is APURANDO. n_amostras then reads N_AVAL.
  - inicio is ignored in this state (no restart).
- APURANDO (exactly one clock):
  - ocupado=1.
  - amostra is ignored.
  - resultado is loaded with the code whose tally is largest. Ties resolve to the lowest code (00 < 01 < 10 < 11).
  - Next state is CONCLUIDO.
- CONCLUIDO:
  - ocupado=0, pronto=1.
  - resultado, tallies and n_amostras are held stable.
  - amostra is ignored.
  - inicio=1 → COLETANDO with tallies and n_amostras cleared on that edge. pronto drops on the same edge; resultado keeps its old value until the next APURANDO.
- Latency:
  - From the edge that accepts the last sample to pronto=1 is 2 clocks.
  - From the inicio edge to the first sample acceptance is 1 clock: amostra on the very next edge counts.
- Arithmetic:
  - The tally sum always equals n_amostras.
  - No tally can exceed N_AVAL, so no overflow or wrap can occur under legal parameters.
  - The tallies must not saturate or wrap.
- Simultaneous events:
  - inicio and amostra on the OCIOSO or CONCLUIDO edge: only the start is taken; the sample is not counted.
  - rst overrides everything.
- Degenerate case N_AVAL=1: the first accepted sample goes straight to APURANDO, and resultado equals that sample's code.

Test Plan:
- Reset: pulse rst asynchronously between edges → all outputs 0 immediately. With no inicio, 20 clocks of amostra=1 leave n_amostras=0.
- Clear majority (N_AVAL=8): inicio, then 8 samples of codes 10,10,01,10,11,10,00,10 → c10=5, c01=1, c11=1, c00=1. pronto rises 2 clocks after the 8th sample; resultado=10.
- Tie-break: 8 samples, four of 11 and four of 01 → resultado=01, c01=4, c11=4, n_amostras=8.
- Gapped strobe: 8 samples interleaved with amostra=0 gaps of 1–3 clocks, with {y1,y0} toggling during gaps → gap values are never counted. Tallies match only the strobed codes; pronto is reached only after the 8th strobe.
- Reset mid-round: after 5 samples assert rst → counts 0, state OCIOSO. A new inicio plus 8 samples of 00 → resultado=00, c00=8.
- Restart and simultaneity: in CONCLUIDO, assert inicio and amostra together with code 11 → c11=0, n_amostras=0, pronto=0. resultado holds its previous value until the new round completes.

Source files
------------

// File: rtl/avaliacao_apurador.sv
// Majority-vote tally of the 2-bit verdict {y1,y0} from the upstream evaluator.
// One round collects N_AVAL strobed samples, then registers the majority code
// and holds it together with the four tallies until the next round starts.
module avaliacao_apurador #(
    parameter int unsigned N_AVAL = 8,
    parameter int unsigned W_CONT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic              amostra,
    input  logic              y1,
    input  logic              y0,
    output logic              ocupado,
    output logic              pronto,
    output logic [1:0]        resultado,
    output logic [W_CONT-1:0] c00,
    output logic [W_CONT-1:0] c01,
    output logic [W_CONT-1:0] c10,
    output logic [W_CONT-1:0] c11,
    output logic [W_CONT-1:0] n_amostras
);

    typedef enum logic [1:0] {
        StOcioso,
        StColetando,
        StApurando,
        StConcluido
    } estado_e;

    estado_e           estado_q, estado_d;
    logic [W_CONT-1:0] cont_q [4];
    logic [W_CONT-1:0] cont_d [4];
    logic [W_CONT-1:0] n_q, n_d;
    logic [1:0]        resultado_q, resultado_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;
    logic [1:0]        codigo;
    logic [1:0]        maioria;

    assign codigo = {y1, y0};

    // Largest tally wins; strict '>' keeps the lowest code on ties.
    always_comb begin
        maioria = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cont_q[i] > cont_q[maioria]) begin
                maioria = 2'(i);
            end
        end
    end

    // Next-state, tally update and registered-output decode.
    always_comb begin
        estado_d    = estado_q;
        cont_d      = cont_q;
        n_d         = n_q;
        resultado_d = resultado_q;
        unique case (estado_q)
            StOcioso, StConcluido: begin
                // A start edge never counts the simultaneous sample.
                if (inicio) begin
                    estado_d = StColetando;
                    cont_d   = '{default: '0};
                    n_d      = '0;
                end
            end
            StColetando: begin
                if (amostra) begin
                    cont_d[codigo] = cont_q[codigo] + 1'b1;
                    n_d            = n_q + 1'b1;
                    if (n_q == W_CONT'(N_AVAL - 1)) begin
                        estado_d = StApurando;
                    end
                end
            end
            StApurando: begin
                resultado_d = maioria;
                estado_d    = StConcluido;
            end
        endcase
        ocupado_d = (estado_d == StColetando) || (estado_d == StApurando);
        // pronto rises one clock after CONCLUIDO is entered and drops on the restart edge.
        pronto_d  = (estado_q == StConcluido) && (estado_d == StConcluido);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= StOcioso;
            cont_q      <= '{default: '0};
            n_q         <= '0;
            resultado_q <= 2'd0;
            ocupado_q   <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            n_q         <= n_d;
            resultado_q <= resultado_d;
            ocupado_q   <= ocupado_d;
            pronto_q    <= pronto_d;
        end
    end

    assign ocupado    = ocupado_q;
    assign pronto     = pronto_q;
    assign resultado  = resultado_q;
    assign c00        = cont_q[0];
    assign c01        = cont_q[1];
    assign c10        = cont_q[2];
    assign c11        = cont_q[3];
    assign n_amostras = n_q;

endmodule

// File: tb/tb_avaliacao_apurador.sv
// Scoreboard bench for avaliacao_apurador: rounds push their expected result,
// a negedge monitor pops and compares whenever pronto rises.
module tb_avaliacao_apurador;

    localparam int unsigned N = 8;
    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         inicio;
    logic         amostra;
    logic         y1;
    logic         y0;
    logic         ocupado;
    logic         pronto;
    logic [1:0]   resultado;
    logic [W-1:0] c00;
    logic [W-1:0] c01;
    logic [W-1:0] c10;
    logic [W-1:0] c11;
    logic [W-1:0] n_amostras;

    typedef struct {
        logic [1:0] res;
        int         cnt[4];
        int         n;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] seq[N];
    logic [1:0] last_res;
    int         errors;
    int         checks;
    logic       pronto_prev;

    avaliacao_apurador #(
        .N_AVAL(N),
        .W_CONT(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inicio    (inicio),
        .amostra   (amostra),
        .y1        (y1),
        .y0        (y0),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .resultado (resultado),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .n_amostras(n_amostras)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ocupado"}, 32'(ocupado), 0);
        chk({nm, "_pronto"}, 32'(pronto), 0);
        chk({nm, "_resultado"}, 32'(resultado), 0);
        chk({nm, "_c00"}, 32'(c00), 0);
        chk({nm, "_c01"}, 32'(c01), 0);
        chk({nm, "_c10"}, 32'(c10), 0);
        chk({nm, "_c11"}, 32'(c11), 0);
        chk({nm, "_n"}, 32'(n_amostras), 0);
    endtask

    // Reference: count occurrences, find the maximum, take the first code reaching it.
    function automatic exp_t modelo();
        exp_t e;
        int   maxv;
        for (int c = 0; c < 4; c++) e.cnt[c] = 0;
        for (int i = 0; i < N; i++) e.cnt[seq[i]]++;
        maxv = 0;
        for (int c = 0; c < 4; c++) if (e.cnt[c] > maxv) maxv = e.cnt[c];
        e.res = 2'd0;
        for (int c = 3; c >= 0; c--) if (e.cnt[c] == maxv) e.res = 2'(c);
        e.n = N;
        return e;
    endfunction

    // Start a round, feed seq with optional gaps, and check the pronto latency.
    task automatic run_round(input int max_gap, input bit with_sample, input logic [1:0] start_code);
        exp_t e;
        e = modelo();
        inicio  = 1'b1;
        amostra = with_sample;
        {y1, y0} = start_code;
        tick();
        inicio  = 1'b0;
        amostra = 1'b0;
        chk("start_n", 32'(n_amostras), 0);
        chk("start_c00", 32'(c00), 0);
        chk("start_c11", 32'(c11), 0);
        chk("start_pronto", 32'(pronto), 0);
        chk("start_ocupado", 32'(ocupado), 1);
        if (with_sample) chk("restart_resultado_held", 32'(resultado), 32'(last_res));
        for (int i = 0; i < N; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                amostra  = 1'b0;
                {y1, y0} = 2'($urandom);
                tick();
            end
            amostra  = 1'b1;
            {y1, y0} = seq[i];
            if (i == N - 1) sb.push_back(e);
            tick();
            if (i == N - 2) begin
                chk("pre_last_n", 32'(n_amostras), N - 1);
                chk("pre_last_pronto", 32'(pronto), 0);
            end
        end
        amostra  = 1'b0;
        {y1, y0} = 2'($urandom);
        chk("lat0_pronto", 32'(pronto), 0);
        chk("lat0_ocupado", 32'(ocupado), 1);
        tick();
        chk("lat1_pronto", 32'(pronto), 0);
        tick();
        chk("lat2_pronto", 32'(pronto), 1);
        last_res = e.res;
    endtask

    // Monitor: on each rising pronto, compare the held result against the scoreboard.
    always @(negedge clk) begin
        if (pronto && !pronto_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pronto", 32'(sb.size()), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_resultado", 32'(resultado), 32'(e.res));
                chk("mon_c00", 32'(c00), 32'(e.cnt[0]));
                chk("mon_c01", 32'(c01), 32'(e.cnt[1]));
                chk("mon_c10", 32'(c10), 32'(e.cnt[2]));
                chk("mon_c11", 32'(c11), 32'(e.cnt[3]));
                chk("mon_n", 32'(n_amostras), 32'(e.n));
                chk("mon_ocupado", 32'(ocupado), 0);
            end
        end
        pronto_prev = pronto;
    end

    initial begin
        errors      = 0;
        checks      = 0;
        pronto_prev = 1'b0;
        last_res    = 2'd0;
        rst         = 1'b1;
        inicio      = 1'b0;
        amostra     = 1'b0;
        {y1, y0}    = 2'd0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Clear majority of 10.
        seq = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2};
        run_round(0, 1'b0, 2'd0);

        // Tie between 01 and 11 resolves to 01.
        seq = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
        run_round(0, 1'b0, 2'd0);

        // Gapped strobe with random codes.
        for (int i = 0; i < N; i++) seq[i] = 2'($urandom);
        run_round(3, 1'b0, 2'd0);

        // Asynchronous reset mid-round discards the round.
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        repeat (5) begin
            amostra  = 1'b1;
            {y1, y0} = 2'($urandom);
            tick();
        end
        amostra = 1'b0;
        chk("mid_n", 32'(n_amostras), 5);
        #3 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        last_res = 2'd0;
        repeat (20) begin
            amostra  = 1'b1;
            {y1, y0} = 2'($urandom);
            tick();
        end
        amostra = 1'b0;
        chk("idle_n", 32'(n_amostras), 0);
        chk("idle_ocupado", 32'(ocupado), 0);

        // All 00 after reset.
        for (int i = 0; i < N; i++) seq[i] = 2'd0;
        run_round(0, 1'b0, 2'd0);

        // Restart from CONCLUIDO with a simultaneous code-11 sample.
        for (int i = 0; i < N; i++) seq[i] = 2'($urandom);
        run_round(1, 1'b1, 2'd3);

        // Random rounds.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) seq[i] = 2'($urandom);
            run_round(2, 1'($urandom), 2'($urandom));
        end

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
